pb_irq_scheduler: RTL and testbench

- Sequences PicoBlaze interrupts: latches edges from up to 8 sources, picks one winner by priority, drives the single CPU interrupt line, and tracks the in-service source until firmware signals end-of-interrupt.
- Sits between the peripheral interrupt sources (UART RX/TX, switch GPI, spare) and the CPU interrupt/interrupt_ack pins.
- Firmware reads the vector and writes clears through the SoC register file.

---
 rtl/pb_irq_scheduler_pkg.sv | 28 ++
 rtl/pb_irq_scheduler_prio_enc.sv | 41 ++++
 rtl/pb_irq_scheduler.sv | 123 ++++++++++++
 tb/tb_pb_irq_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_irq_scheduler_pkg.sv
// Shared definitions for the PicoBlaze interrupt scheduler: FSM states, vector layout
// and well-known source indices.
package pb_irq_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2,
    GAP     = 2'd3
  } irq_state_e;

  localparam int VEC_VALID_BIT = 7;
  localparam int SRC_ID_W      = 3;
  localparam int GAP_CNT_W     = 4;

  localparam int UART_RX  = 0;
  localparam int UART_TX  = 1;
  localparam int SWITCHES = 2;

  function automatic logic [7:0] make_vector(input logic [SRC_ID_W-1:0] id);
    logic [7:0] v;
    v                 = '0;
    v[VEC_VALID_BIT]  = 1'b1;
    v[SRC_ID_W-1:0]   = id;
    return v;
  endfunction

endpackage

// File: rtl/pb_irq_scheduler_prio_enc.sv
// Rotating priority encoder: first set candidate at or after start_i, wrapping to index 0.
// start_i = 0 gives plain lowest-index-wins; also used by the register-file read path.
module pb_irq_prio_enc
  import pb_irq_scheduler_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]  cand_i,
  input  logic [SRC_ID_W-1:0] start_i,
  output logic [SRC_ID_W-1:0] id_o,
  output logic                valid_o
);

  logic [SRC_ID_W-1:0] hi_id;
  logic [SRC_ID_W-1:0] lo_id;
  logic                hi_valid;
  logic                lo_valid;

  // Descending scan so the last hit written is the lowest index in each half.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_i[i]) begin
        if (i >= int'(start_i)) begin
          hi_id    = SRC_ID_W'(i);
          hi_valid = 1'b1;
        end else begin
          lo_id    = SRC_ID_W'(i);
          lo_valid = 1'b1;
        end
      end
    end
  end

  assign id_o    = hi_valid ? hi_id : lo_id;
  assign valid_o = hi_valid | lo_valid;

endmodule

// File: rtl/pb_irq_scheduler.sv
// PicoBlaze interrupt scheduler: edge-latched sources, one in-service winner, EOI via clear.
// Define PB_IRQ_ROUND_ROBIN_EN to rotate priority after each end-of-interrupt.
module pb_irq_scheduler
  import pb_irq_scheduler_pkg::*;
#(
  parameter int NUM_SRC    = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic [NUM_SRC-1:0] int_clear,
  input  logic               cpu_inta_i,
  output logic               int_o,
  output logic [7:0]         int_vector,
  output logic [NUM_SRC-1:0] interrupts,
  output logic               busy_o
);

  irq_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   src_q;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic [7:0]           vec_q, vec_d;
  logic [GAP_CNT_W-1:0] gap_q, gap_d;
  logic [7:0]           clear_ext;
  logic [SRC_ID_W-1:0]  start_ptr;
  logic [SRC_ID_W-1:0]  win_id;
  logic                 win_valid;
  logic                 eoi_hit;

  // A new rising edge beats a simultaneous clear on the same bit.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    assign pending_d[gi] = (int_src[gi] & ~src_q[gi]) | (pending_q[gi] & ~int_clear[gi]);
  end

  assign clear_ext = 8'(int_clear);
  assign eoi_hit   = (state_q == SERVICE) && clear_ext[vec_q[SRC_ID_W-1:0]];

`ifdef PB_IRQ_ROUND_ROBIN_EN
  logic [SRC_ID_W-1:0] last_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= SRC_ID_W'(NUM_SRC - 1);
    end else if (eoi_hit) begin
      last_q <= vec_q[SRC_ID_W-1:0];
    end
  end

  assign start_ptr = (last_q == SRC_ID_W'(NUM_SRC - 1)) ? '0 : last_q + 1'b1;
`else
  assign start_ptr = '0;
`endif

  pb_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .cand_i  (pending_q & int_mask),
    .start_i (start_ptr),
    .id_o    (win_id),
    .valid_o (win_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          vec_d   = make_vector(win_id);
          state_d = ASSERT;
        end
      end
      ASSERT: begin
        // Winner is committed: mask/clear changes here do not retract the request.
        if (cpu_inta_i) begin
          state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi_hit) begin
          vec_d   = '0;
          gap_d   = GAP_CNT_W'(GAP_CYCLES);
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q <= GAP_CNT_W'(1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      src_q     <= '0;
      pending_q <= '0;
      vec_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= int_src;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      gap_q     <= gap_d;
    end
  end

  // Decoded from the state register so reset drops the line without waiting for a clock.
  assign int_o      = (state_q == ASSERT);
  assign busy_o     = (state_q != IDLE);
  assign int_vector = vec_q;
  assign interrupts = pending_q;

endmodule

// File: tb/tb_pb_irq_scheduler.sv
// Directed plus randomized checks of pb_irq_scheduler against a transaction-level model
// (pending bits from edges/clears, winner from a modular priority search).
module tb_pb_irq_scheduler;

  localparam int NSRC = 8;
  localparam int GAP  = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [NSRC-1:0] int_src;
  logic [NSRC-1:0] int_mask;
  logic [NSRC-1:0] int_clear;
  logic            cpu_inta_i;
  logic            int_o;
  logic [7:0]      int_vector;
  logic [NSRC-1:0] interrupts;
  logic            busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_pend;
  logic [7:0] prev_src;
  int         served_last;

  always #5 clk = ~clk;

  pb_irq_scheduler #(
    .NUM_SRC    (NSRC),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .int_src    (int_src),
    .int_mask   (int_mask),
    .int_clear  (int_clear),
    .cpu_inta_i (cpu_inta_i),
    .int_o      (int_o),
    .int_vector (int_vector),
    .interrupts (interrupts),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled at the edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_i) begin
      exp_pend = '0;
      prev_src = '0;
    end else begin
      exp_pend = (exp_pend & ~int_clear) | (int_src & ~prev_src);
      prev_src = int_src;
    end
    #1;
  endtask

  function automatic int search_start();
`ifdef PB_IRQ_ROUND_ROBIN_EN
    return (served_last + 1) % NSRC;
`else
    return 0;
`endif
  endfunction

  function automatic int pred(input logic [7:0] cand);
    int st;
    st = search_start();
    for (int k = 0; k < NSRC; k++) begin
      int i;
      i = (st + k) % NSRC;
      if (((cand >> i) & 8'd1) != 8'd0) return i;
    end
    return -1;
  endfunction

  task automatic pulse_inta();
    cpu_inta_i = 1'b1;
    tick();
    cpu_inta_i = 1'b0;
  endtask

  task automatic pulse_clr(input logic [7:0] v);
    int_clear = v;
    tick();
    int_clear = '0;
  endtask

  task automatic gap_wait(input string tag);
    for (int k = 0; k < GAP; k++) begin
      tick();
      chk({tag, "_gap_int"}, 32'(int_o), 0);
    end
    chk({tag, "_gap_idle"}, 32'(busy_o), 0);
  endtask

  // Expects int_o already high for the model's winner; acknowledges and ends it.
  task automatic serve(input string tag);
    int w;
    w = pred(exp_pend & int_mask);
    chk({tag, "_int"}, 32'(int_o), 1);
    chk({tag, "_vec"}, 32'(int_vector), 32'(8'h80 | 8'(w)));
    pulse_inta();
    chk({tag, "_ack_int"}, 32'(int_o), 0);
    pulse_clr(8'(1 << w));
    served_last = w;
    chk({tag, "_eoi_vec"}, 32'(int_vector), 0);
    $display("serve %s: source %0d vector 0x%02h", tag, w, 8'h80 | 8'(w));
  endtask

  initial begin
    rst_i       = 1'b0;
    int_src     = '0;
    int_mask    = '0;
    int_clear   = '0;
    cpu_inta_i  = 1'b0;
    exp_pend    = '0;
    prev_src    = '0;
    served_last = NSRC - 1;

    // Reset held while sources toggle.
    tick(); int_src = 8'hFF; tick(); int_src = '0; tick();
    chk("rst_int", 32'(int_o), 0);
    chk("rst_irqs", 32'(interrupts), 0);
    chk("rst_vec", 32'(int_vector), 0);
    chk("rst_busy", 32'(busy_o), 0);
    rst_i = 1'b1;
    tick(); tick();
    chk("post_rst_int", 32'(int_o), 0);
    chk("post_rst_irqs", 32'(interrupts), 32'(exp_pend));
    $display("step reset: int_o=%0b vec=0x%02h", int_o, int_vector);

    // Single source 1.
    int_mask = 8'h07; int_src = 8'h02; tick();
    chk("single_pend", 32'(interrupts), 32'h02);
    chk("single_early", 32'(int_o), 0);
    int_src = '0; tick();
    chk("single_vec", 32'(int_vector), 32'h81);
    serve("single");
    chk("single_busy", 32'(busy_o), 1);
    gap_wait("single");

    // Simultaneous edges on 0 and 2.
    int_mask = 8'hFF; int_src = 8'h05; tick(); int_src = '0; tick();
    serve("simul_a");
    gap_wait("simul_a"); tick();
    serve("simul_b");
    gap_wait("simul_b");
    int_src = 8'h05; tick(); int_src = '0; tick();
    serve("simul_c");
    gap_wait("simul_c"); tick();
    serve("simul_d");
    gap_wait("simul_d");

    // Masked source 3; commitment survives mask and clear.
    int_mask = 8'h00; int_src = 8'h08; tick(); int_src = '0; tick();
    chk("mask_pend", 32'(interrupts), 32'h08);
    chk("mask_int", 32'(int_o), 0);
    int_mask = 8'h08; tick();
    chk("mask_en_int", 32'(int_o), 1);
    chk("mask_en_vec", 32'(int_vector), 32'h83);
    int_mask = 8'h00; int_clear = 8'h08; tick(); int_clear = '0;
    chk("mask_hold_int", 32'(int_o), 1);
    chk("mask_hold_vec", 32'(int_vector), 32'h83);
    chk("mask_hold_pend", 32'(interrupts), 32'(exp_pend));
    pulse_inta();
    chk("mask_ack", 32'(int_o), 0);
    pulse_clr(8'h08); served_last = 3;
    chk("mask_eoi_vec", 32'(int_vector), 0);
    gap_wait("mask");

    // Re-edge coincident with EOI on source 0.
    int_mask = 8'h01; int_src = 8'h01; tick(); int_src = '0; tick();
    chk("coll_vec", 32'(int_vector), 32'h80);
    pulse_inta();
    int_src = 8'h01; int_clear = 8'h01; tick(); int_src = '0; int_clear = '0;
    served_last = 0;
    chk("coll_pend", 32'(interrupts), 32'h01);
    gap_wait("coll"); tick();
    serve("coll_again");
    gap_wait("coll_again");

    // Spurious acknowledge in IDLE.
    pulse_inta();
    chk("spur_busy", 32'(busy_o), 0);
    chk("spur_int", 32'(int_o), 0);
    chk("spur_vec", 32'(int_vector), 0);

    // Randomized episodes.
    for (int ep = 0; ep < 20; ep++) begin
      logic [7:0] m, e;
      m = 8'($urandom_range(1, 255));
      e = 8'($urandom_range(1, 255));
      if ((e & m) == 8'h00) m = m | e;
      int_mask = m; int_src = e; tick(); int_src = '0; tick();
      begin
        int w;
        w = pred(exp_pend & m);
        chk("rnd_int", 32'(int_o), 1);
        chk("rnd_vec", 32'(int_vector), 32'(8'h80 | 8'(w)));
        pulse_inta();
        chk("rnd_ack", 32'(int_o), 0);
        pulse_clr(8'($urandom_range(0, 255)) & ~8'(1 << w));
        chk("rnd_other_clr", 32'(interrupts), 32'(exp_pend));
        chk("rnd_svc_vec", 32'(int_vector), 32'(8'h80 | 8'(w)));
        int_mask = '0;
        pulse_clr(8'hFF);
        served_last = w;
        chk("rnd_eoi_vec", 32'(int_vector), 0);
        chk("rnd_eoi_pend", 32'(interrupts), 32'(exp_pend));
        $display("random ep %0d: edges 0x%02h mask 0x%02h served %0d", ep, e, m, w);
      end
      gap_wait("rnd");
    end

    // Asynchronous reset while asserting.
    int_mask = 8'h02; int_src = 8'h02; tick(); int_src = '0; tick();
    chk("arst_pre_int", 32'(int_o), 1);
    #2; rst_i = 1'b0; #1;
    chk("arst_int", 32'(int_o), 0);
    chk("arst_vec", 32'(int_vector), 0);
    chk("arst_irqs", 32'(interrupts), 0);
    chk("arst_busy", 32'(busy_o), 0);
    tick();
    rst_i = 1'b1; served_last = NSRC - 1;
    tick(); tick();
    chk("arst_after_int", 32'(int_o), 0);
    int_mask = 8'hFF; int_src = 8'h05; tick(); int_src = '0; tick();
    chk("arst_fresh_vec", 32'(int_vector), 32'h80);
    $display("step async reset: vec=0x%02h", int_vector);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
